spi_rb_master: RTL
==================

// Module: spi_rb_master
// PURPOSE
//  SPI slave (mode 0, MSB first) to register-bus bridge; the initiator side of rb_minivan's bus.
//  Decodes SPI frames from an external host and issues the register-bus accesses.
//  - Reads: drives address/reg_en, captures data_read_out.
//  - Writes: drives address/data_write_in/write_en.
//  Sits between the chip-level SPI pins and rb_minivan. Fully synchronous to clk.
// PARAMETERS
//  ADR_BITS  8  register-bus address width (<=8); low ADR_BITS of the address byte are used
//  READ_LAT  1  clk cycles from address/reg_en valid to data_read_out valid in the register bank
// PORTS
//  clk            in   1         system clock; must be >= 16x spi_sclk
//  reset          in   1         asynchronous, active-high reset
//  spi_sclk       in   1         SPI clock from host (asynchronous to clk)
//  spi_csn        in   1         SPI chip select, active low
//  spi_mosi       in   1         SPI data host->block
//  spi_miso       out  1         SPI data block->host
//  spi_miso_oe    out  1         pad output enable for spi_miso
//  address        out  ADR_BITS  register-bus address
//  data_write_in  out  8         register-bus write data
//  data_read_out  in   8         register-bus read data
//  reg_en         out  1         register-bus access enable
//  write_en       out  1         register-bus write strobe, 1 clk pulse
//  frame_err      out  1         1 clk pulse: csn rose with a frame not on a whole-byte boundary
// BEHAVIOUR
//  Reset: every output 0; FSM = IDLE; address counter, shift registers and bit counter cleared.
//  Input sync: spi_sclk, spi_csn, spi_mosi pass through 2-FF synchronisers.
//   - sclk rise/fall detected on the synchronised signal.
//   - mosi sampled on sclk rise; spi_miso updated on sclk fall.
//  Frame: byte0 = cmd; cmd[7]=1 write, cmd[7]=0 read; cmd[6:0] ignored.
//   byte1 = start address. byte2..N = data (burst).
//  FSM: IDLE -(csn fall)-> CMD -(8 bits)-> ADDR -(8 bits)-> WDATA | RDATA.
//   WDATA and RDATA loop per byte. Any state -(csn high)-> IDLE.
//  Write: on the 8th rising sclk edge of each data byte:
//   - address <= current addr, data_write_in <= byte;
//   - write_en = reg_en = 1 for exactly one clk, next clk after the edge detect;
//   - address and data_write_in are held until the next access.
//   - Then current addr <= addr+1, wrapping 2^ADR_BITS-1 -> 0.
//  Read: when the address byte completes:
//   - drive address, reg_en=1 for READ_LAT+1 clks, capture data_read_out on the last of them, reg_en -> 0;
//   - captured byte is loaded into the MISO shift register before the next sclk fall;
//   - on loading a byte, immediately prefetch addr+1 (same wrap) into a holding register for the next byte.
//  spi_miso: MSB of the shift register, 0 outside RDATA.
//  spi_miso_oe = 1 only while csn low and FSM in RDATA.
//  Timing: sync (3 clk) + fetch (READ_LAT+1) must fit in half an sclk period; guaranteed by the 16x ratio.
//  csn rise mid-byte:
//   - partial byte discarded; no write issued;
//   - an in-flight read completes on the bus but its data is dropped;
//   - frame_err pulses if the bit count is not a multiple of 8.
//  csn rise in the same clk as a write strobe: the strobe completes.
//  Read-only frames never assert write_en.
//  Reset mid-frame: immediate return to reset state; host must re-assert csn.
// STRUCTURE
//  minivan_pkg:
//   - typedef enum spi_rb_state_t {IDLE,CMD,ADDR,WDATA,RDATA};
//   - localparam SPI_CMD_WRITE_BIT = 7.
//  Sub-module spi_sync_edge: 2-FF synchroniser plus rise/fall pulse outputs; one instance each for sclk, csn, mosi.
//  Top holds FSM, bit counter, shift registers, address counter and bus sequencer.
// TESTING (bench instantiates spi_rb_master + rb_minivan, clk = 16x sclk)
//  1. Reset released, no SPI: all outputs 0; spi_miso_oe stays 0.
//  2. Write 0x80,0x12,0x3C: one write_en pulse, address=0x12, data=0x3C; readback of 0x12 returns 0x3C.
//  3. Read 0x00,0x03 then 8 clocks: MISO shifts 0x11 (spare_0 reset value); write_en never asserted.
//  4. Burst read 0x00,0x12 then 3 bytes: MISO 0x85,0x85,0x85 (pwm red/green/blue reset values).
//  5. Burst write 0x80,0xFF,0xA1,0xB2: writes at 0xFF then 0x00 (wrap); spare/enable at 0x00 become 0xB2.
//  6. Write 0x80,0x04 then 5 bits, csn high: no write_en; frame_err pulses once; addr 0x04 still reads 0x22.

Source files
------------

// File: rtl/minivan_pkg.sv
// Shared types and constants for the minivan register-bus slice.
package minivan_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    WDATA = 3'd3,
    RDATA = 3'd4
  } spi_rb_state_t;

  localparam int SPI_CMD_WRITE_BIT = 7;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for one asynchronous input, with single-cycle
// rise/fall pulses derived from the synchronised level.
module spi_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic meta;
  logic sync;
  logic prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
    end else begin
      meta <= din;
      sync <= meta;
      prev <= sync;
    end
  end

  assign level = sync;
  assign rise  = sync & ~prev;
  assign fall  = ~sync & prev;

endmodule

// File: rtl/spi_rb_master.sv
// SPI mode-0 slave that turns host frames (cmd, address, data burst) into
// register-bus reads and writes.
module spi_rb_master
  import minivan_pkg::*;
#(
  parameter int ADR_BITS = 8,
  parameter int READ_LAT = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                spi_sclk,
  input  logic                spi_csn,
  input  logic                spi_mosi,
  output logic                spi_miso,
  output logic                spi_miso_oe,
  output logic [ADR_BITS-1:0] address,
  output logic [7:0]          data_write_in,
  input  logic [7:0]          data_read_out,
  output logic                reg_en,
  output logic                write_en,
  output logic                frame_err
);

  localparam logic [ADR_BITS-1:0] ADDR_ONE = ADR_BITS'(1);
  localparam logic [7:0]          LAT_INIT = 8'(READ_LAT);

  logic sclk_level, sclk_rise, sclk_fall;
  logic csn_level,  csn_rise,  csn_fall;
  logic mosi_level, mosi_rise, mosi_fall;

  spi_sync_edge u_sync_sclk (
    .clk(clk), .reset(reset), .din(spi_sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  spi_sync_edge u_sync_csn (
    .clk(clk), .reset(reset), .din(spi_csn),
    .level(csn_level), .rise(csn_rise), .fall(csn_fall)
  );

  spi_sync_edge u_sync_mosi (
    .clk(clk), .reset(reset), .din(spi_mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, sclk_level, mosi_rise, mosi_fall};

  spi_rb_state_t       state;
  logic [2:0]          bit_cnt;
  logic [7:0]          rx_shift;
  logic [7:0]          tx_shift;
  logic [7:0]          hold_data;
  logic                is_write;
  logic [ADR_BITS-1:0] cur_addr;
  logic                fetching;
  logic [7:0]          fetch_cnt;
  logic [7:0]          rx_byte;

  assign rx_byte  = {rx_shift[6:0], mosi_level};
  assign spi_miso = tx_shift[7];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      bit_cnt       <= 3'd0;
      rx_shift      <= 8'd0;
      tx_shift      <= 8'd0;
      hold_data     <= 8'd0;
      is_write      <= 1'b0;
      cur_addr      <= '0;
      fetching      <= 1'b0;
      fetch_cnt     <= 8'd0;
      address       <= '0;
      data_write_in <= 8'd0;
      reg_en        <= 1'b0;
      write_en      <= 1'b0;
      frame_err     <= 1'b0;
      spi_miso_oe   <= 1'b0;
    end else begin
      write_en  <= 1'b0;
      frame_err <= 1'b0;
      if (write_en) reg_en <= 1'b0;

      // Read sequencer runs independently of csn so an aborted fetch still finishes on the bus.
      if (fetching) begin
        if (fetch_cnt == 8'd0) begin
          hold_data <= data_read_out;
          reg_en    <= 1'b0;
          fetching  <= 1'b0;
        end else begin
          fetch_cnt <= fetch_cnt - 8'd1;
        end
      end

      if (csn_level) begin
        state       <= IDLE;
        bit_cnt     <= 3'd0;
        tx_shift    <= 8'd0;
        spi_miso_oe <= 1'b0;
        if (csn_rise && bit_cnt != 3'd0) frame_err <= 1'b1;
      end else if (state == IDLE) begin
        if (csn_fall) begin
          state   <= CMD;
          bit_cnt <= 3'd0;
        end
      end else begin
        if (sclk_rise) begin
          bit_cnt  <= bit_cnt + 3'd1;
          rx_shift <= rx_byte;
          if (bit_cnt == 3'd7) begin
            case (state)
              CMD: begin
                is_write <= rx_byte[SPI_CMD_WRITE_BIT];
                state    <= ADDR;
              end
              ADDR: begin
                cur_addr <= rx_byte[ADR_BITS-1:0];
                if (is_write) begin
                  state <= WDATA;
                end else begin
                  state       <= RDATA;
                  spi_miso_oe <= 1'b1;
                  address     <= rx_byte[ADR_BITS-1:0];
                  reg_en      <= 1'b1;
                  fetching    <= 1'b1;
                  fetch_cnt   <= LAT_INIT;
                end
              end
              WDATA: begin
                address       <= cur_addr;
                data_write_in <= rx_byte;
                write_en      <= 1'b1;
                reg_en        <= 1'b1;
                cur_addr      <= cur_addr + ADDR_ONE;
              end
              default: ;
            endcase
          end
        end

        // The fall that closes a byte presents the next byte's MSB and prefetches the one after.
        if (sclk_fall && state == RDATA) begin
          if (bit_cnt == 3'd0) begin
            tx_shift  <= hold_data;
            address   <= cur_addr + ADDR_ONE;
            cur_addr  <= cur_addr + ADDR_ONE;
            reg_en    <= 1'b1;
            fetching  <= 1'b1;
            fetch_cnt <= LAT_INIT;
          end else begin
            tx_shift <= {tx_shift[6:0], 1'b0};
          end
        end
      end
    end
  end

endmodule
